tsen_conv_sched: RTL and testbench

TSEN_CONV_SCHED -- requirements
Module: tsen_conv_sched

---
 rtl/tsen_sched_pkg.sv | 19 +
 rtl/tsen_period_timer.sv | 35 +++
 rtl/tsen_conv_sched.sv | 186 ++++++++++++++++++
 tb/tb_tsen_conv_sched.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tsen_sched_pkg.sv
// Shared types and defaults for the temperature-sensor conversion scheduler.
// Contents:
//   DataWDef         default width of one conversion result
//   TimeoutCyclesDef default cycle budget from start pulse to abort
//   state_e          scheduler FSM states
package tsen_sched_pkg;

  localparam int unsigned DataWDef         = 24;
  localparam int unsigned TimeoutCyclesDef = 4096;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StConvert,
    StCapture,
    StNext
  } state_e;

endpackage

// File: rtl/tsen_period_timer.sv
// Free-running period counter that produces the sequence tick.
// Ports:
//   clk_i    clock, rising edge
//   rst_i    asynchronous active-high reset
//   en_i     counting enable; while low the counter is held at 0
//   period_i cycles between ticks (0 behaves as 1)
//   tick_o   high in the cycle the count reaches max(period_i,1)-1
module tsen_period_timer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [15:0] period_i,
  output logic        tick_o
);

  logic [15:0] r_cnt;
  logic [15:0] w_max;
  logic        w_tick;

  assign w_max  = (period_i == 16'd0) ? 16'd0 : period_i - 16'd1;
  // >= rather than == so a period shortened mid-count wraps at once.
  assign w_tick = en_i && (r_cnt >= w_max);
  assign tick_o = w_tick;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= 16'd0;
    end else if (!en_i || w_tick) begin
      r_cnt <= 16'd0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/tsen_conv_sched.sv
// Sequences conversions over NumSensors temperature sensors on every period tick,
// captures results, and flags timeouts, dropped ticks and (optionally) threshold alarms.
// Optional feature: define TSEN_THRESH_EN to enable the alarm compare against thresh_i;
// without it alarm_o is tied low and thresh_i is ignored.
// Ports:
//   clk_i, rst_i   clock and asynchronous active-high reset
//   en_i           scheduler enable; low forces IDLE and restarts the period count
//   period_i       cycles between sequence ticks
//   thresh_i       alarm threshold (unsigned)
//   clr_i          clears sticky err_o / overrun_o / alarm_o
//   start_o        one-cycle start pulse to the sensor being converted
//   done_i, data_i per-sensor done level and result
//   result_o       last captured result per sensor; valid_o marks captured slices
//   upd_o          one-cycle pulse per capture
//   busy_o         sequence in progress; err_o per-sensor timeout
//   overrun_o      tick dropped while busy; alarm_o result above threshold
module tsen_conv_sched
  import tsen_sched_pkg::*;
#(
  parameter int unsigned NumSensors    = 2,
  parameter int unsigned DataW         = DataWDef,
  parameter int unsigned TimeoutCycles = TimeoutCyclesDef
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        en_i,
  input  logic [15:0]                 period_i,
  input  logic [DataW-1:0]            thresh_i,
  input  logic                        clr_i,
  output logic [NumSensors-1:0]       start_o,
  input  logic [NumSensors-1:0]       done_i,
  input  logic [NumSensors*DataW-1:0] data_i,
  output logic [NumSensors*DataW-1:0] result_o,
  output logic [NumSensors-1:0]       valid_o,
  output logic                        upd_o,
  output logic                        busy_o,
  output logic [NumSensors-1:0]       err_o,
  output logic                        overrun_o,
  output logic                        alarm_o
);

  localparam int unsigned IdxW = (NumSensors > 1) ? $clog2(NumSensors) : 1;
  localparam int unsigned ToW  = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [ToW-1:0]  ToLast  = ToW'(TimeoutCycles - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NumSensors - 1);

  state_e                      r_state, w_state_d;
  logic [IdxW-1:0]             r_idx, w_idx_d;
  logic [ToW-1:0]              r_to;
  logic [NumSensors*DataW-1:0] r_result;
  logic [NumSensors-1:0]       r_valid;
  logic                        r_upd;
  logic [NumSensors-1:0]       r_err;
  logic                        r_overrun;

  logic                  w_tick;
  logic                  w_capture;
  logic                  w_timeout;
  logic [NumSensors-1:0] w_start;
  logic [NumSensors-1:0] w_err_set;
  logic [DataW-1:0]      w_data_sel;

  tsen_period_timer u_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (en_i),
    .period_i(period_i),
    .tick_o  (w_tick)
  );

  assign w_data_sel = data_i[r_idx*DataW +: DataW];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= StIdle;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_d;
      r_idx   <= w_idx_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    w_capture = 1'b0;
    w_timeout = 1'b0;
    if (!en_i) begin
      w_state_d = StIdle;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_tick) begin
            w_idx_d   = '0;
            w_state_d = StStart;
          end
        end
        StStart: w_state_d = StConvert;
        StConvert: begin
          // done wins over a timeout landing in the same cycle
          if (done_i[r_idx]) begin
            w_state_d = StCapture;
          end else if (r_to == ToLast) begin
            w_timeout = 1'b1;
            w_state_d = StNext;
          end
        end
        StCapture: begin
          w_capture = 1'b1;
          w_state_d = StNext;
        end
        StNext: begin
          if (r_idx == IdxLast) begin
            w_state_d = StIdle;
          end else begin
            w_idx_d   = r_idx + 1'b1;
            w_state_d = StStart;
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  // Saturates at ToLast so it cannot wrap while waiting in CONVERT.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_to <= '0;
    end else if (r_state == StStart) begin
      r_to <= '0;
    end else if (r_state == StConvert && r_to != ToLast) begin
      r_to <= r_to + 1'b1;
    end
  end

  always_comb begin
    w_start   = '0;
    w_err_set = '0;
    if (r_state == StStart) w_start[r_idx] = 1'b1;
    if (w_timeout) w_err_set[r_idx] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_result  <= '0;
      r_valid   <= '0;
      r_upd     <= 1'b0;
      r_err     <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_upd <= w_capture;
      if (w_capture) begin
        r_result[r_idx*DataW +: DataW] <= w_data_sel;
        r_valid[r_idx]                 <= 1'b1;
      end
      // sticky flags: a set in the same cycle as clr_i wins
      r_err     <= (r_err & ~{NumSensors{clr_i}}) | w_err_set;
      r_overrun <= (r_overrun & ~clr_i) | (w_tick && r_state != StIdle);
    end
  end

`ifdef TSEN_THRESH_EN
  logic r_alarm;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_alarm <= 1'b0;
    end else begin
      r_alarm <= (r_alarm & ~clr_i) | (w_capture && (w_data_sel > thresh_i));
    end
  end
  assign alarm_o = r_alarm;
`else
  logic w_unused_thresh;
  assign w_unused_thresh = ^thresh_i;
  assign alarm_o = 1'b0;
`endif

  assign start_o   = w_start;
  assign result_o  = r_result;
  assign valid_o   = r_valid;
  assign upd_o     = r_upd;
  assign busy_o    = (r_state != StIdle);
  assign err_o     = r_err;
  assign overrun_o = r_overrun;

endmodule

// File: tb/tb_tsen_conv_sched.sv
// Bench for tsen_conv_sched: behavioural sensor model, table-driven sequences,
// randomized sequences checked against a cycle-count model, and directed corner cases.
module tb_tsen_conv_sched;

  localparam int NS = 2;
  localparam int DW = 24;
  localparam int TO = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             clr = 1'b0;
  logic [15:0]      period = 16'd10;
  logic [DW-1:0]    thresh = 24'hFFFFFF;
  logic [NS-1:0]    start;
  logic [NS-1:0]    done = '0;
  logic [NS*DW-1:0] data = '0;
  logic [NS*DW-1:0] result;
  logic [NS-1:0]    valid;
  logic             upd, busy, overrun, alarm;
  logic [NS-1:0]    err;

  always #5 clk = ~clk;

  tsen_conv_sched #(
    .NumSensors   (NS),
    .DataW        (DW),
    .TimeoutCycles(TO)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .en_i     (en),
    .period_i (period),
    .thresh_i (thresh),
    .clr_i    (clr),
    .start_o  (start),
    .done_i   (done),
    .data_i   (data),
    .result_o (result),
    .valid_o  (valid),
    .upd_o    (upd),
    .busy_o   (busy),
    .err_o    (err),
    .overrun_o(overrun),
    .alarm_o  (alarm)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Sensor model: on start_o[k], done drops; L cycles later done rises with sdat[k].
  int            cyc = 0;
  int            lat[NS];
  logic [DW-1:0] sdat[NS];
  int            due[NS];
  int            upd_cnt = 0;
  int            start_q[$];

  initial begin
    for (int k = 0; k < NS; k++) begin
      due[k] = -1; lat[k] = 0; sdat[k] = '0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        done = '0;
        for (int k = 0; k < NS; k++) due[k] = -1;
      end else begin
        if (upd) upd_cnt++;
        for (int k = 0; k < NS; k++) begin
          if (start[k]) begin
            start_q.push_back(k);
            done[k] = 1'b0;
            due[k]  = (lat[k] == 0) ? -1 : cyc + lat[k];
          end else if (due[k] == cyc) begin
            done[k] = 1'b1;
            data[k*DW +: DW] = sdat[k];
            due[k] = -1;
          end
        end
      end
    end
  end

  // Reference model state
  logic [DW-1:0] exp_res[NS];
  logic [NS-1:0] exp_valid = '0;

  // START + conversion + CAPTURE + NEXT, or START + full timeout + NEXT.
  function automatic int sensor_cycles(input int l);
    return (l == 0) ? TO + 2 : l + 3;
  endfunction

  task automatic check_results(input string tag);
    for (int k = 0; k < NS; k++)
      check($sformatf("%s result%0d", tag, k), 64'(result[k*DW +: DW]), 64'(exp_res[k]));
    check({tag, " valid"}, 64'(valid), 64'(exp_valid));
  endtask

  // Runs two back-to-back sequences from a freshly enabled scheduler.
  task automatic run_seq(input string tag, input int per, input int l0, input int l1,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                         input logic [1:0] exp_err, input int exp_dur);
    int ph, ts1, ti1, ts2, ti2, u0, pe, k, n_upd;
    ph = 0; ts1 = 0; ti1 = 0; ts2 = 0; ti2 = 0;
    en = 1'b0; clr = 1'b1; step(); clr = 1'b0;
    period = 16'(per); lat[0] = l0; lat[1] = l1; sdat[0] = d0; sdat[1] = d1;
    start_q.delete();
    u0 = upd_cnt;
    en = 1'b1;
    for (int t = 1; t <= 800 && ph < 4; t++) begin
      step();
      case (ph)
        0: if (busy) begin ts1 = t; ph = 1; end
        1: if (!busy) begin ti1 = t; ph = 2; end
        2: if (busy) begin ts2 = t; ph = 3; end
        default: if (!busy) begin ti2 = t; ph = 4; end
      endcase
    end
    en = 1'b0;
    pe = (per == 0) ? 1 : per;
    k = (exp_dur + 1 + pe - 1) / pe;
    n_upd = 0;
    if (!exp_err[0]) begin exp_res[0] = d0; exp_valid[0] = 1'b1; n_upd++; end
    if (!exp_err[1]) begin exp_res[1] = d1; exp_valid[1] = 1'b1; n_upd++; end
    check({tag, " phases"}, 64'(ph), 64'd4);
    check({tag, " first_start"}, 64'(ts1), 64'(pe));
    check({tag, " dur1"}, 64'(ti1 - ts1), 64'(exp_dur));
    check({tag, " restart_gap"}, 64'(ts2 - ts1), 64'(k * pe));
    check({tag, " dur2"}, 64'(ti2 - ts2), 64'(exp_dur));
    check({tag, " upd_count"}, 64'(upd_cnt - u0), 64'(2 * n_upd));
    check({tag, " err"}, 64'(err), 64'(exp_err));
    check({tag, " overrun"}, 64'(overrun), 64'(k > 1));
    check({tag, " start_n"}, 64'(start_q.size()), 64'd4);
    for (int i = 0; i < start_q.size() && i < 4; i++)
      check({tag, " start_order"}, 64'(start_q[i]), 64'(i % 2));
    check_results(tag);
    step();
  endtask

  typedef struct {
    int            per;
    int            l0;
    int            l1;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic [1:0]    exp_err;
    int            exp_dur;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int l0, l1, per, ts, u0;
    logic [1:0] e;
    logic [DW-1:0] r0, r1;
    logic exp_alarm;
`ifdef TSEN_THRESH_EN
    exp_alarm = 1'b1;
`else
    exp_alarm = 1'b0;
`endif
    for (int i = 0; i < NS; i++) exp_res[i] = '0;
    vecs[0] = '{10, 5, 5, 24'h000123, 24'h000456, 2'b00, 16};
    vecs[1] = '{3, 1, 16, 24'hABCDEF, 24'h00F00D, 2'b00, 23};
    vecs[2] = '{5, 2, 0, 24'h111111, 24'h222222, 2'b10, 23};
    vecs[3] = '{0, 3, 4, 24'h0000AA, 24'hFFFFFF, 2'b00, 13};
    vecs[4] = '{7, 0, 0, 24'h333333, 24'h444444, 2'b11, 36};

    // Reset state
    repeat (3) step();
    check("reset result", 64'(result), 64'd0);
    check("reset flags", 64'({valid, err, start, upd, busy, overrun, alarm}), 64'd0);
    rst = 1'b0;
    step();

    foreach (vecs[i])
      run_seq($sformatf("vec%0d", i), vecs[i].per, vecs[i].l0, vecs[i].l1,
              vecs[i].d0, vecs[i].d1, vecs[i].exp_err, vecs[i].exp_dur);

    for (int n = 0; n < 6; n++) begin
      per = $urandom_range(0, 30);
      l0 = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, TO);
      l1 = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, TO);
      e = {l1 == 0, l0 == 0};
      r0 = DW'($urandom); r1 = DW'($urandom);
      run_seq($sformatf("rand%0d", n), per, l0, l1, r0, r1, e,
              sensor_cycles(l0) + sensor_cycles(l1));
    end

    // en_i dropped during CONVERT: abort without capture
    clr = 1'b1; step(); clr = 1'b0;
    period = 16'd2; lat[0] = 10; lat[1] = 5; sdat[0] = 24'h0BAD00; sdat[1] = 24'h0BAD01;
    en = 1'b1;
    ts = 0;
    for (int t = 1; t <= 20 && ts == 0; t++) begin
      step();
      if (busy) ts = t;
    end
    check("endrop started", 64'(ts), 64'd2);
    repeat (3) step();
    u0 = upd_cnt;
    en = 1'b0;
    step();
    check("endrop busy", 64'(busy), 64'd0);
    repeat (15) step();
    check("endrop upd", 64'(upd_cnt - u0), 64'd0);
    check_results("endrop");

    // Overrun: ticks every cycle while busy; clr loses against a same-cycle drop
    sdat[0] = exp_res[0]; sdat[1] = exp_res[1]; lat[0] = 16; lat[1] = 16;
    period = 16'd1;
    en = 1'b1;
    repeat (25) step();
    check("ovr set", 64'(overrun), 64'd1);
    clr = 1'b1; step(); clr = 1'b0;
    check("ovr clr_vs_tick", 64'(overrun), 64'd1);
    en = 1'b0; clr = 1'b1; step(); clr = 1'b0;
    check("ovr cleared", 64'(overrun), 64'd0);
    check("ovr idle", 64'(busy), 64'd0);
    exp_valid[0] = 1'b1;

    // Threshold alarm: equal value does not trip, one above does (when enabled)
    thresh = 24'h000200;
    run_seq("thr_eq", 4, 2, 2, 24'h000200, 24'h000100, 2'b00, 10);
    check("alarm equal", 64'(alarm), 64'd0);
    run_seq("thr_gt", 4, 2, 2, 24'h000201, 24'h000100, 2'b00, 10);
    check("alarm above", 64'(alarm), 64'(exp_alarm));
    thresh = 24'hFFFFFF;

    // Asynchronous reset mid-CONVERT, then restart after a full period
    period = 16'd6; lat[0] = 8; lat[1] = 8;
    en = 1'b1;
    ts = 0;
    for (int t = 1; t <= 20 && ts == 0; t++) begin
      step();
      if (busy) ts = t;
    end
    repeat (3) step();
    rst = 1'b1;
    #1;
    check("arst result", 64'(result), 64'd0);
    check("arst valid", 64'(valid), 64'd0);
    check("arst busy", 64'(busy), 64'd0);
    check("arst others", 64'({err, start, upd, overrun, alarm}), 64'd0);
    for (int i = 0; i < NS; i++) exp_res[i] = '0;
    exp_valid = '0;
    step(); step();
    rst = 1'b0;
    ts = 0;
    for (int t = 1; t <= 40 && ts == 0; t++) begin
      step();
      if (busy) begin
        ts = t;
        check("post_reset start0", 64'(start), 64'd1);
      end
    end
    check("post_reset first_start", 64'(ts), 64'd6);
    en = 1'b0;
    step();
    check_results("post_reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
